// File: rtl/calc_req_driver.sv
// calc_req_driver
//   Accepts one request at a time, drives its operands and opcode to a
//   fixed-latency calculator, samples the calculator result CALC_LATENCY
//   edges after the accept, and holds it as a response until the consumer
//   takes it.
//
// Parameters
//   CALC_LATENCY  edges from operand update to a valid result (1..15)
//   TAG_W         width of the per-transaction sequence tag
//
// Ports
//   clk, reset_high              clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_opcode     request payload
//   A, B, opcode                 operands/opcode driven to the calculator
//   result                       calculator result (33 bits)
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_opcode,
//   rsp_tag                      response payload
//   busy                         FSM is not idle
//   stat_txn_cnt                 (only with CALC_DRV_STATS_EN) saturating
//                                count of response handshakes
//
// Optional feature macro: CALC_DRV_STATS_EN
module calc_req_driver #(
  parameter int CALC_LATENCY = 1,
  parameter int TAG_W        = 8
) (
  input  logic             clk,
  input  logic             reset_high,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_opcode,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [2:0]       opcode,
  input  logic [32:0]      result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [32:0]      rsp_result,
  output logic [2:0]       rsp_opcode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef CALC_DRV_STATS_EN
  ,
  output logic [15:0]      stat_txn_cnt
`endif
);

  if (CALC_LATENCY < 1 || CALC_LATENCY > 15) begin : g_lat_chk
    $error("calc_req_driver: CALC_LATENCY must be 1..15");
  end

  localparam logic [3:0] LAT = 4'(CALC_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       lat_cnt;
  logic [TAG_W-1:0] tag_cnt;   // next tag to hand out
  logic [TAG_W-1:0] txn_tag;   // tag of the in-flight transaction

  logic accept, capture, rsp_hs;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid && (state == ST_IDLE);
  assign capture   = (state == ST_WAIT) && (lat_cnt == 4'd1);
  assign rsp_hs    = (state == ST_RESP) && rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset_high) begin
    if (reset_high) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)  state_nxt = ST_WAIT;
      ST_WAIT: if (capture) state_nxt = ST_RESP;
      ST_RESP: if (rsp_hs)  state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_high) begin
    if (reset_high) begin
      A          <= '0;
      B          <= '0;
      opcode     <= '0;
      lat_cnt    <= '0;
      tag_cnt    <= '0;
      txn_tag    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_opcode <= '0;
      rsp_tag    <= '0;
    end else begin
      if (accept) begin
        A       <= req_a;
        B       <= req_b;
        opcode  <= req_opcode;
        lat_cnt <= LAT;
        txn_tag <= tag_cnt;
        tag_cnt <= tag_cnt + TAG_W'(1);   // wraps naturally at 2^TAG_W
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      // Sample on the CALC_LATENCY-th edge after accept.
      if (capture) begin
        rsp_result <= result;
        rsp_opcode <= opcode;
        rsp_tag    <= txn_tag;
        rsp_valid  <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef CALC_DRV_STATS_EN
  always_ff @(posedge clk or posedge reset_high) begin
    if (reset_high)                           stat_txn_cnt <= '0;
    else if (rsp_hs && stat_txn_cnt != 16'hFFFF) stat_txn_cnt <= stat_txn_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_calc_req_driver.sv
module tb_calc_req_driver;

  localparam int TAG_W = 8;

  logic clk = 1'b0;
  logic reset_high;
  always #5 clk = ~clk;

  // Latency-1 instance
  logic             req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [31:0]      req_a, req_b, A, B;
  logic [2:0]       req_opcode, opcode, rsp_opcode;
  logic [32:0]      result, rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  // Latency-4 instance
  logic             req_valid4, req_ready4, rsp_valid4, rsp_ready4, busy4;
  logic [31:0]      req_a4, req_b4, A4, B4;
  logic [2:0]       req_opcode4, opcode4, rsp_opcode4;
  logic [32:0]      result4, rsp_result4;
  logic [TAG_W-1:0] rsp_tag4;

`ifdef CALC_DRV_STATS_EN
  logic [15:0] stat, stat4;
`endif

  calc_req_driver #(.CALC_LATENCY(1), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_high(reset_high),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .A(A), .B(B), .opcode(opcode), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_opcode(rsp_opcode), .rsp_tag(rsp_tag),
    .busy(busy)
`ifdef CALC_DRV_STATS_EN
    , .stat_txn_cnt(stat)
`endif
  );

  calc_req_driver #(.CALC_LATENCY(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .reset_high(reset_high),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .req_opcode(req_opcode4),
    .A(A4), .B(B4), .opcode(opcode4), .result(result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_result(rsp_result4), .rsp_opcode(rsp_opcode4), .rsp_tag(rsp_tag4),
    .busy(busy4)
`ifdef CALC_DRV_STATS_EN
    , .stat_txn_cnt(stat4)
`endif
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic [32:0]      res;
    logic [32:0]      exp_res;
    logic [TAG_W-1:0] exp_tag;
  } vec_t;

  // One full transaction on the latency-1 instance with rsp_ready held high.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [32:0] res, input logic [32:0] exp_res,
                         input logic [TAG_W-1:0] exp_tag);
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_opcode = op; result = res; rsp_ready = 1'b1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);                       // accept edge passed
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_F00D; req_opcode = ~op;
    check("busy_wait", 64'(busy), 64'd1);
    check("rsp_valid_early", 64'(rsp_valid), 64'd0);
    check("A_drv", 64'(A), 64'(a));
    check("B_drv", 64'(B), 64'(b));
    check("opcode_drv", 64'(opcode), 64'(op));
    @(negedge clk);                       // capture edge passed
    result = ~res;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_result", 64'(rsp_result), 64'(exp_res));
    check("rsp_opcode", 64'(rsp_opcode), 64'(op));
    check("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
    check("A_hold_resp", 64'(A), 64'(a));
    @(negedge clk);                       // handshake edge passed
    check("rsp_valid_clr", 64'(rsp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  vec_t vecs[5];

  initial begin
    reset_high = 1'b1;
    req_valid = 0; req_a = 0; req_b = 0; req_opcode = 0; result = 0; rsp_ready = 0;
    req_valid4 = 0; req_a4 = 0; req_b4 = 0; req_opcode4 = 0; result4 = 0; rsp_ready4 = 1;

    vecs[0] = '{32'd1,          32'd2,          3'd1, 33'd3,            33'd3,            8'd1};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd7, 33'h1_FFFF_FFFF,  33'h1_FFFF_FFFF,  8'd2};
    vecs[2] = '{32'h8000_0000,  32'h8000_0000,  3'd2, 33'h1_0000_0000,  33'h1_0000_0000,  8'd3};
    vecs[3] = '{32'h1234_5678,  32'h0,          3'd4, 33'h0,            33'h0,            8'd4};
    vecs[4] = '{32'hA5A5_A5A5,  32'h5A5A_5A5A,  3'd6, 33'h0_FFFF_FFFF,  33'h0_FFFF_FFFF,  8'd5};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_A", 64'(A), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    reset_high = 1'b0;
    #1 check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Single transaction: 5 + 3 -> 8, tag 0
    run_txn(32'd5, 32'd3, 3'd0, 33'd8, 33'd8, 8'd0);

    // Table of vectors, tags 1..5
    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].exp_res, vecs[i].exp_tag);

    // Backpressure, tag 6
    @(negedge clk);
    req_valid = 1; req_a = 32'd7; req_b = 32'd9; req_opcode = 3'd3;
    result = 33'h0_1234_5678; rsp_ready = 0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("bp_valid", 64'(rsp_valid), 64'd1);
    check("bp_tag", 64'(rsp_tag), 64'd6);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_a = 32'hFFFF_0000 + 32'(i); result = 33'(i);
      @(negedge clk);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_result", 64'(rsp_result), 64'h0_1234_5678);
      check("bp_hold_tag", 64'(rsp_tag), 64'd6);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_A_hold", 64'(A), 64'd7);
    end
    // Request offered in the handshake cycle must not be taken then
    rsp_ready = 1; req_valid = 1; req_a = 32'h0000_AAAA; req_b = 32'd1; req_opcode = 3'd5;
    result = 33'd42;
    @(negedge clk);
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_idle", 64'(req_ready), 64'd1);
    check("bp_no_accept_A", 64'(A), 64'd7);
    @(negedge clk);
    req_valid = 0;
    check("bp_next_accept_busy", 64'(busy), 64'd1);
    check("bp_next_accept_A", 64'(A), 64'h0000_AAAA);
    @(negedge clk);
    check("bp_next_valid", 64'(rsp_valid), 64'd1);
    check("bp_next_result", 64'(rsp_result), 64'd42);
    check("bp_next_opcode", 64'(rsp_opcode), 64'd5);
    check("bp_next_tag", 64'(rsp_tag), 64'd7);
    @(negedge clk);
    check("bp_next_clr", 64'(rsp_valid), 64'd0);

    // Latency-4 sweep: result4 = 100+n before edge n; edge 4 must be sampled
    @(negedge clk);
    req_valid4 = 1; req_a4 = 32'd77; req_b4 = 32'd88; req_opcode4 = 3'd2; result4 = 33'd100;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      req_valid4 = 0; req_a4 = 32'd0;
      result4 = 33'd100 + 33'(n);
      if (n <= 5) check("lat4_valid", 64'(rsp_valid4), 64'(n == 5));
      if (n <= 4) check("lat4_A_hold", 64'(A4), 64'd77);
      if (n == 5) begin
        check("lat4_result", 64'(rsp_result4), 64'd104);
        check("lat4_opcode", 64'(rsp_opcode4), 64'd2);
      end
      if (n == 6) check("lat4_clr", 64'(rsp_valid4), 64'd0);
    end

    // Reset asserted mid-WAIT
    @(negedge clk);
    req_valid = 1; req_a = 32'd11; req_b = 32'd22; req_opcode = 3'd1; result = 33'd99;
    @(negedge clk);
    req_valid = 0;
    check("mid_wait_busy", 64'(busy), 64'd1);
    #2 reset_high = 1;
    #1;
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_A", 64'(A), 64'd0);
    check("async_rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset_high = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    run_txn(32'd2, 32'd2, 3'd0, 33'd4, 33'd4, 8'd0);

    // Tag wrap: 257 back-to-back transactions from a fresh reset
    @(negedge clk);
    reset_high = 1;
    @(negedge clk);
    reset_high = 0;
    for (int i = 0; i < 257; i++)
      run_txn(32'(i), 32'(i + 1), 3'(i), 33'(i * 3), 33'(i * 3), TAG_W'(i));
`ifdef CALC_DRV_STATS_EN
    check("stat_txn_cnt", 64'(stat), 64'd257);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
